lsu_req: RTL and testbench

- Request side of the load/store path; the counterpart of the LSU writeback stage.
- Takes a load/store from ID/EX and decodes the target (DTCM or ITCM) from the address. Checks alignment, builds the write mask and lane-aligned store data, and runs a valid/ready request to the selected TCM.
- Waits for the TCM response and right-aligns load data. Presents per-TCM result pulses, data and error flags to the writeback stage, and stalls ID/EX while the access is in flight.

---
 rtl/lsu_req.sv | 175 +++++++++++++++++
 tb/tb_lsu_req.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_req.sv
// Load/store request side: decodes DTCM/ITCM target, formats stores, runs the
// valid/ready request and returns right-aligned load data to writeback.
`ifndef ZCRV_XLEN
`define ZCRV_XLEN 32
`endif

// state | meaning
// IDLE  | waiting for a load/store from ID/EX
// REQ   | req_valid high toward selected TCM, mem_* stable
// WAIT  | request accepted, waiting for rsp_valid
// DONE  | one-cycle completion: result or error pulse
module lsu_req #(
  parameter logic [31:0] DTCM_BASE = 32'h8000_0000,
  parameter logic [31:0] DTCM_MASK = 32'hFFFF_0000,
  parameter logic [31:0] ITCM_BASE = 32'h0000_0000,
  parameter logic [31:0] ITCM_MASK = 32'hFFFF_0000,
  parameter int          TIMEOUT   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ls_valid_from_idex,
  input  logic                  rden_from_idex,
  input  logic [4:0]            load_info_from_idex,
  input  logic [2:0]            store_info_from_idex,
  input  logic [`ZCRV_XLEN-1:0] ls_addr_from_idex,
  input  logic [`ZCRV_XLEN-1:0] ls_wdata_from_idex,
  output logic                  lsu_stall_to_idex,
  output logic                  dtcm_req_valid,
  input  logic                  dtcm_req_ready,
  output logic                  itcm_req_valid,
  input  logic                  itcm_req_ready,
  output logic [`ZCRV_XLEN-1:0] mem_addr,
  output logic                  mem_we,
  output logic [3:0]            mem_wmask,
  output logic [`ZCRV_XLEN-1:0] mem_wdata,
  input  logic                  dtcm_rsp_valid,
  input  logic [`ZCRV_XLEN-1:0] dtcm_rsp_rdata,
  input  logic                  itcm_rsp_valid,
  input  logic [`ZCRV_XLEN-1:0] itcm_rsp_rdata,
  output logic                  res_dtcm_to_wb,
  output logic                  res_itcm_to_wb,
  output logic [`ZCRV_XLEN-1:0] data_dtcm_to_wb,
  output logic [`ZCRV_XLEN-1:0] data_itcm_to_wb,
  output logic                  ls_addr_error_to_wb,
  output logic                  ls_buserr_to_wb
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state;

  logic             tgt_dtcm;
  logic             op_load;
  logic [1:0]       addr_lo;
  logic [TMO_W-1:0] tmo_cnt;

  logic        dtcm_hit, itcm_hit, is_half, is_word, misaligned;
  logic        sel_ready, sel_rsp;
  logic [31:0] sel_rdata, st_wdata;
  logic [3:0]  st_wmask;
  logic        unused_ok;

  // load_info = {lb,lh,lw,lbu,lhu}, store_info = {sb,sh,sw}; byte ops never misalign
  assign is_half    = rden_from_idex ? (load_info_from_idex[3] | load_info_from_idex[0])
                                     : store_info_from_idex[1];
  assign is_word    = rden_from_idex ? load_info_from_idex[2] : store_info_from_idex[0];
  assign misaligned = (is_half & ls_addr_from_idex[0]) |
                      (is_word & (ls_addr_from_idex[1:0] != 2'b00));
  assign dtcm_hit   = (ls_addr_from_idex & DTCM_MASK) == DTCM_BASE;
  assign itcm_hit   = (ls_addr_from_idex & ITCM_MASK) == ITCM_BASE;
  assign unused_ok  = ^{load_info_from_idex[4], load_info_from_idex[1]};

  always_comb begin
    st_wdata = ls_wdata_from_idex;
    st_wmask = 4'b1111;
    if (store_info_from_idex[2]) begin
      st_wdata = {4{ls_wdata_from_idex[7:0]}};
      st_wmask = 4'b0001 << ls_addr_from_idex[1:0];
    end else if (store_info_from_idex[1]) begin
      st_wdata = {2{ls_wdata_from_idex[15:0]}};
      st_wmask = ls_addr_from_idex[1] ? 4'b1100 : 4'b0011;
    end
  end

  assign sel_ready = tgt_dtcm ? dtcm_req_ready : itcm_req_ready;
  assign sel_rsp   = tgt_dtcm ? dtcm_rsp_valid : itcm_rsp_valid;
  assign sel_rdata = (tgt_dtcm ? dtcm_rsp_rdata : itcm_rsp_rdata) >> {addr_lo, 3'b000};

  assign lsu_stall_to_idex = ls_valid_from_idex & (state != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      tgt_dtcm            <= 1'b0;
      op_load             <= 1'b0;
      addr_lo             <= 2'b00;
      tmo_cnt             <= '0;
      dtcm_req_valid      <= 1'b0;
      itcm_req_valid      <= 1'b0;
      mem_addr            <= '0;
      mem_we              <= 1'b0;
      mem_wmask           <= 4'b0000;
      mem_wdata           <= '0;
      res_dtcm_to_wb      <= 1'b0;
      res_itcm_to_wb      <= 1'b0;
      data_dtcm_to_wb     <= '0;
      data_itcm_to_wb     <= '0;
      ls_addr_error_to_wb <= 1'b0;
      ls_buserr_to_wb     <= 1'b0;
    end else begin
      // completion/error flags are single-cycle pulses, set only on entry to DONE
      res_dtcm_to_wb      <= 1'b0;
      res_itcm_to_wb      <= 1'b0;
      ls_addr_error_to_wb <= 1'b0;
      ls_buserr_to_wb     <= 1'b0;
      case (state)
        IDLE: begin
          if (ls_valid_from_idex) begin
            op_load  <= rden_from_idex;
            addr_lo  <= ls_addr_from_idex[1:0];
            tgt_dtcm <= dtcm_hit;
            if (misaligned) begin
              ls_addr_error_to_wb <= 1'b1;
              state               <= DONE;
            end else if (!dtcm_hit && !itcm_hit) begin
              ls_buserr_to_wb <= 1'b1;
              state           <= DONE;
            end else begin
              tmo_cnt        <= '0;
              dtcm_req_valid <= dtcm_hit;
              itcm_req_valid <= !dtcm_hit;
              mem_addr       <= {ls_addr_from_idex[31:2], 2'b00};
              mem_we         <= !rden_from_idex;
              mem_wmask      <= rden_from_idex ? 4'b1111 : st_wmask;
              mem_wdata      <= st_wdata;
              state          <= REQ;
            end
          end
        end
        REQ: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (sel_ready) begin
            dtcm_req_valid <= 1'b0;
            itcm_req_valid <= 1'b0;
            state          <= WAIT;
          end else if (tmo_cnt >= TMO_LAST) begin
            dtcm_req_valid  <= 1'b0;
            itcm_req_valid  <= 1'b0;
            ls_buserr_to_wb <= 1'b1;
            state           <= DONE;
          end
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (sel_rsp) begin
            if (tgt_dtcm) begin
              res_dtcm_to_wb <= 1'b1;
              if (op_load) data_dtcm_to_wb <= sel_rdata;
            end else begin
              res_itcm_to_wb <= 1'b1;
              if (op_load) data_itcm_to_wb <= sel_rdata;
            end
            state <= DONE;
          end else if (tmo_cnt >= TMO_LAST) begin
            ls_buserr_to_wb <= 1'b1;
            state           <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_req.sv
// Directed bench for lsu_req: DTCM/ITCM loads and stores, alignment and bus
// errors, timeout, and reset in the middle of an access.
`timescale 1ns/1ps
module tb_lsu_req;
  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid, rden;
  logic [4:0]  load_info;
  logic [2:0]  store_info;
  logic [31:0] ls_addr, ls_wdata;
  logic        stall;
  logic        dtcm_req_valid, dtcm_req_ready, itcm_req_valid, itcm_req_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic        dtcm_rsp_valid, itcm_rsp_valid;
  logic [31:0] dtcm_rsp_rdata, itcm_rsp_rdata;
  logic        res_dtcm, res_itcm, addr_err, buserr;
  logic [31:0] data_dtcm, data_itcm;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [4:0] LW  = 5'b00100, LH = 5'b01000, LBU = 5'b00010;
  localparam logic [2:0] SB  = 3'b100,   SH = 3'b010,   SW  = 3'b001;

  lsu_req dut (
    .clk(clk), .rst(rst),
    .ls_valid_from_idex(ls_valid), .rden_from_idex(rden),
    .load_info_from_idex(load_info), .store_info_from_idex(store_info),
    .ls_addr_from_idex(ls_addr), .ls_wdata_from_idex(ls_wdata),
    .lsu_stall_to_idex(stall),
    .dtcm_req_valid(dtcm_req_valid), .dtcm_req_ready(dtcm_req_ready),
    .itcm_req_valid(itcm_req_valid), .itcm_req_ready(itcm_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .dtcm_rsp_valid(dtcm_rsp_valid), .dtcm_rsp_rdata(dtcm_rsp_rdata),
    .itcm_rsp_valid(itcm_rsp_valid), .itcm_rsp_rdata(itcm_rsp_rdata),
    .res_dtcm_to_wb(res_dtcm), .res_itcm_to_wb(res_itcm),
    .data_dtcm_to_wb(data_dtcm), .data_itcm_to_wb(data_itcm),
    .ls_addr_error_to_wb(addr_err), .ls_buserr_to_wb(buserr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic [4:0] li, input logic [2:0] si,
                       input logic [31:0] a, input logic [31:0] wd);
    ls_valid = 1'b1; rden = rd; load_info = li; store_info = si;
    ls_addr = a; ls_wdata = wd;
    #1;
  endtask

  initial begin
    rst = 1'b1; ls_valid = 1'b0; rden = 1'b0; load_info = '0; store_info = '0;
    ls_addr = '0; ls_wdata = '0;
    dtcm_req_ready = 1'b0; itcm_req_ready = 1'b0;
    dtcm_rsp_valid = 1'b0; itcm_rsp_valid = 1'b0;
    dtcm_rsp_rdata = '0; itcm_rsp_rdata = '0;
    tick(); tick();
    chk("rst_dreq", dtcm_req_valid, 0);
    chk("rst_ireq", itcm_req_valid, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mask", mem_wmask, 0);
    chk("rst_flags", {res_dtcm, res_itcm, addr_err, buserr}, 0);
    chk("rst_data", data_dtcm | data_itcm, 0);
    rst = 1'b0;
    tick();

    // lw DTCM, ready held off two cycles
    issue(1'b1, LW, 3'b000, 32'h8000_0010, 32'h0);
    chk("lw_stall_idle", stall, 1);
    tick();
    chk("lw_req1", dtcm_req_valid, 1);
    chk("lw_ireq", itcm_req_valid, 0);
    chk("lw_addr", mem_addr, 32'h8000_0010);
    chk("lw_we_mask", {mem_we, mem_wmask}, 5'b0_1111);
    tick();
    chk("lw_req2", dtcm_req_valid, 1);
    dtcm_req_ready = 1'b1;
    chk("lw_req3", dtcm_req_valid, 1);
    tick();
    dtcm_req_ready = 1'b0;
    chk("lw_req_drop", dtcm_req_valid, 0);
    chk("lw_no_res_wait", res_dtcm, 0);
    dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = 32'hDEAD_BEEF;
    tick();
    dtcm_rsp_valid = 1'b0;
    chk("lw_res", res_dtcm, 1);
    chk("lw_data", data_dtcm, 32'hDEAD_BEEF);
    chk("lw_stall_done", stall, 0);
    ls_valid = 1'b0;
    tick();
    chk("lw_res_once", res_dtcm, 0);

    // sb DTCM byte 3
    issue(1'b0, 5'b0, SB, 32'h8000_0003, 32'h0000_00A5);
    dtcm_req_ready = 1'b1;
    tick();
    chk("sb_we", mem_we, 1);
    chk("sb_mask", mem_wmask, 4'b1000);
    chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("sb_addr", mem_addr, 32'h8000_0000);
    tick();
    dtcm_req_ready = 1'b0;
    dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = 32'h1234_5678;
    tick();
    dtcm_rsp_valid = 1'b0;
    chk("sb_res", res_dtcm, 1);
    chk("sb_data_kept", data_dtcm, 32'hDEAD_BEEF);
    ls_valid = 1'b0;
    tick();

    // sh DTCM upper half
    issue(1'b0, 5'b0, SH, 32'h8000_0006, 32'h0000_BEEF);
    dtcm_req_ready = 1'b1;
    tick();
    chk("sh_mask", mem_wmask, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    chk("sh_addr", mem_addr, 32'h8000_0004);
    tick();
    dtcm_req_ready = 1'b0;
    dtcm_rsp_valid = 1'b1;
    tick();
    dtcm_rsp_valid = 1'b0;
    chk("sh_res", res_dtcm, 1);
    ls_valid = 1'b0;
    tick();

    // lbu ITCM with a stray DTCM response during WAIT
    issue(1'b1, LBU, 3'b000, 32'h0000_0102, 32'h0);
    itcm_req_ready = 1'b1;
    tick();
    chk("lbu_ireq", itcm_req_valid, 1);
    chk("lbu_dreq", dtcm_req_valid, 0);
    chk("lbu_addr", mem_addr, 32'h0000_0100);
    tick();
    itcm_req_ready = 1'b0;
    dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = 32'h0BAD_0BAD;
    tick();
    dtcm_rsp_valid = 1'b0;
    chk("lbu_ignore_dtcm", {res_dtcm, res_itcm}, 2'b00);
    itcm_rsp_valid = 1'b1; itcm_rsp_rdata = 32'h1122_3344;
    tick();
    itcm_rsp_valid = 1'b0;
    chk("lbu_res", {res_dtcm, res_itcm}, 2'b01);
    chk("lbu_data", data_itcm, 32'h0000_1122);
    chk("lbu_dtcm_kept", data_dtcm, 32'hDEAD_BEEF);
    ls_valid = 1'b0;
    tick();

    // lh misaligned
    issue(1'b1, LH, 3'b000, 32'h8000_0001, 32'h0);
    tick();
    chk("lh_addr_err", addr_err, 1);
    chk("lh_no_req", {dtcm_req_valid, itcm_req_valid}, 2'b00);
    chk("lh_no_res", {res_dtcm, res_itcm, buserr}, 3'b000);
    chk("lh_stall_done", stall, 0);
    ls_valid = 1'b0;
    tick();
    chk("lh_err_once", addr_err, 0);

    // sw unmapped
    issue(1'b0, 5'b0, SW, 32'h4000_0000, 32'h5555_AAAA);
    tick();
    chk("sw_buserr", buserr, 1);
    chk("sw_no_req", {dtcm_req_valid, itcm_req_valid, addr_err}, 3'b000);
    ls_valid = 1'b0;
    tick();
    chk("sw_buserr_once", buserr, 0);

    // DTCM lw with no response -> timeout after 16 cycles in REQ+WAIT
    issue(1'b1, LW, 3'b000, 32'h8000_0020, 32'h0);
    dtcm_req_ready = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("tmo_early", buserr, 0);
    end
    tick();
    chk("tmo_buserr", buserr, 1);
    chk("tmo_no_res", res_dtcm, 0);
    dtcm_req_ready = 1'b0;
    ls_valid = 1'b0;
    tick();
    dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = 32'h7777_7777;
    tick();
    dtcm_rsp_valid = 1'b0;
    chk("late_rsp_res", res_dtcm, 0);
    chk("late_rsp_data", data_dtcm, 32'hDEAD_BEEF);
    tick();

    // reset during WAIT, then a clean lw
    issue(1'b1, LW, 3'b000, 32'h8000_0030, 32'h0);
    dtcm_req_ready = 1'b1;
    tick();
    tick();
    dtcm_req_ready = 1'b0;
    rst = 1'b1; ls_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("rstw_req", {dtcm_req_valid, itcm_req_valid}, 2'b00);
    chk("rstw_flags", {res_dtcm, res_itcm, addr_err, buserr}, 4'b0000);
    chk("rstw_data", data_dtcm, 0);
    dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = 32'h9999_9999;
    tick();
    dtcm_rsp_valid = 1'b0;
    chk("rstw_ignore", res_dtcm, 0);
    issue(1'b1, LW, 3'b000, 32'h8000_0040, 32'h0);
    dtcm_req_ready = 1'b1;
    tick();
    chk("post_req", dtcm_req_valid, 1);
    chk("post_addr", mem_addr, 32'h8000_0040);
    tick();
    dtcm_req_ready = 1'b0;
    dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = 32'hCAFE_F00D;
    tick();
    dtcm_rsp_valid = 1'b0;
    chk("post_res", res_dtcm, 1);
    chk("post_data", data_dtcm, 32'hCAFE_F00D);
    ls_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
